// File: rtl/alu_ctrl.sv
// Sequencing controller for an external ALU: fetches operands from a 16x16
// register file, drives the ALU for one cycle, then writes back result and PSR.
module alu_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [7:0]  instr_op,
   input  logic [3:0]  instr_rd,
   input  logic [3:0]  instr_rs,
   input  logic [7:0]  instr_imm,
   input  logic        instr_is_imm,
   input  logic        instr_imm_zext,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [7:0]  alu_op,
   output logic        alu_cin,
   input  logic [15:0] alu_c,
   input  logic [4:0]  alu_flags,
   output logic [4:0]  psr,
   output logic        done,
   input  logic [3:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   state_t      r_state;
   logic [7:0]  r_op;
   logic [3:0]  r_rd;
   logic [3:0]  r_rs;
   logic [7:0]  r_imm;
   logic        r_is_imm;
   logic        r_zext;
   logic [15:0] r_alu_a;
   logic [15:0] r_alu_b;
   logic [7:0]  r_alu_op;
   logic        r_alu_cin;
   logic [15:0] r_res;
   logic [4:0]  r_flags;
   logic [4:0]  r_psr;
   logic        r_done;
   logic [15:0] r_regs [16];

   logic [15:0] w_imm_ext;
   logic        w_no_wb;

   always_comb begin
      w_imm_ext = r_zext ? {8'h00, r_imm} : {{8{r_imm[7]}}, r_imm};
      w_no_wb   = (r_op == 8'h00) || (r_op == 8'h0B) || (r_op == 8'h0F) ||
                  (r_op[7:4] == 4'hB) || (r_op[7:4] == 4'hE);
   end

   // ALU drive registers are loaded only on the READ edge and cleared on the
   // EXEC edge, so they read as zero/NOP in every other state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_rd      <= '0;
         r_rs      <= '0;
         r_imm     <= '0;
         r_is_imm  <= 1'b0;
         r_zext    <= 1'b0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_op  <= '0;
         r_alu_cin <= 1'b0;
         r_res     <= '0;
         r_flags   <= '0;
         r_psr     <= '0;
         r_done    <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_op     <= instr_op;
                  r_rd     <= instr_rd;
                  r_rs     <= instr_rs;
                  r_imm    <= instr_imm;
                  r_is_imm <= instr_is_imm;
                  r_zext   <= instr_imm_zext;
                  r_state  <= S_READ;
               end
            end
            S_READ: begin
               r_alu_a   <= r_regs[r_rd];
               r_alu_b   <= r_is_imm ? w_imm_ext : r_regs[r_rs];
               r_alu_op  <= r_op;
               r_alu_cin <= r_psr[0];
               r_state   <= S_EXEC;
            end
            S_EXEC: begin
               r_res     <= alu_c;
               r_flags   <= alu_flags;
               r_alu_a   <= '0;
               r_alu_b   <= '0;
               r_alu_op  <= '0;
               r_alu_cin <= 1'b0;
               r_done    <= 1'b1;
               r_state   <= S_WB;
            end
            S_WB: begin
               if (!w_no_wb) begin
                  r_regs[r_rd] <= r_res;
               end
               if (r_op != 8'h00) begin
                  r_psr <= r_flags;
               end
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign instr_ready = (r_state == S_IDLE) && !reset;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_op      = r_alu_op;
   assign alu_cin     = r_alu_cin;
   assign psr         = r_psr;
   assign done        = r_done;
   assign dbg_data    = r_regs[dbg_addr];

endmodule
